// File: rtl/vga_display_engine.sv
// VGA timing generator with pipelined background/sprite colour path.
// Fetch address leads the displayed pixel by LAT+1 pixel ticks.
module vga_display_engine #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int CLK_DIV   = 4,
   parameter int SYNC_POL  = 0,
   parameter int COLOR_W   = 4,
   parameter int LAT       = 2,
   parameter int ICON_SIZE = 16
) (
   input  logic                               sys_clk,
   input  logic                               sys_rst,
   input  logic [9:0]                         ball_loc_X,
   input  logic [8:0]                         ball_loc_Y,
   input  logic [7:0]                         world_pixel,
   input  logic [1:0]                         icon_pixel,
   output logic                               pix_tick,
   output logic [9:0]                         pixel_row,
   output logic [9:0]                         pixel_column,
   output logic [2*$clog2(ICON_SIZE)-1:0]     icon_addr,
   output logic                               frame_start,
   output logic                               horiz_sync,
   output logic                               vert_sync,
   output logic                               video_on,
   output logic [COLOR_W-1:0]                 red,
   output logic [COLOR_W-1:0]                 green,
   output logic [COLOR_W-1:0]                 blue
);

   localparam int   IW      = $clog2(ICON_SIZE);
   localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic L_POL   = (SYNC_POL != 0);

   logic [4:0] r_div;
   logic [9:0] r_h;
   logic [9:0] r_v;
   logic [9:0] r_bx;
   logic [8:0] r_by;

   logic       w_div_last;
   logic       w_h_last;
   logic       w_v_last;
   logic       w_de0;
   logic       w_hs0;
   logic       w_vs0;
   logic       w_hit0;
   logic [9:0] w_dx;
   logic [9:0] w_dy;
   logic [3:0] w_st0;
   logic [3:0] w_std;

   logic [COLOR_W-1:0] w_red;
   logic [COLOR_W-1:0] w_green;
   logic [COLOR_W-1:0] w_blue;

   // Repeat a colour field MSB-first and keep the top COLOR_W bits.
   function automatic logic [COLOR_W-1:0] f_expand3(input logic [2:0] f);
      logic [3*COLOR_W-1:0] rep;
      rep = {COLOR_W{f}};
      return rep[3*COLOR_W-1 -: COLOR_W];
   endfunction

   function automatic logic [COLOR_W-1:0] f_expand2(input logic [1:0] f);
      logic [2*COLOR_W-1:0] rep;
      rep = {COLOR_W{f}};
      return rep[2*COLOR_W-1 -: COLOR_W];
   endfunction

   assign w_div_last = (r_div == 5'(CLK_DIV - 1));
   // Gated by reset so that no tick is reported while the block is held.
   assign pix_tick   = w_div_last & ~sys_rst;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_div <= '0;
      end else if (w_div_last) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 5'd1;
      end
   end

   assign w_h_last = (r_h == 10'(H_TOTAL - 1));
   assign w_v_last = (r_v == 10'(V_TOTAL - 1));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_h <= '0;
         r_v <= '0;
      end else if (pix_tick) begin
         if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
         end else begin
            r_h <= r_h + 10'd1;
         end
      end
   end

   assign pixel_row    = r_v;
   assign pixel_column = r_h;
   assign frame_start  = pix_tick && w_h_last && (r_v == 10'(V_ACTIVE - 1));

   // Sprite position is sampled once per frame so a frame never tears.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_bx <= '0;
         r_by <= '0;
      end else if (frame_start) begin
         r_bx <= ball_loc_X;
         r_by <= ball_loc_Y;
      end
   end

   assign w_de0 = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
   assign w_hs0 = (r_h >= 10'(H_ACTIVE + H_FP)) &&
                  (r_h <= 10'(H_ACTIVE + H_FP + H_SYNC - 1));
   assign w_vs0 = (r_v >= 10'(V_ACTIVE + V_FP)) &&
                  (r_v <= 10'(V_ACTIVE + V_FP + V_SYNC - 1));

   assign w_dx      = r_h - r_bx;
   assign w_dy      = r_v - {1'b0, r_by};
   assign w_hit0    = (w_dx < 10'(ICON_SIZE)) && (w_dy < 10'(ICON_SIZE));
   assign icon_addr = {w_dy[IW-1:0], w_dx[IW-1:0]};

   assign w_st0 = {w_hit0, w_de0, w_vs0, w_hs0};

   generate
      if (LAT == 0) begin : g_nodly
         assign w_std = w_st0;
      end else begin : g_dly
         localparam int DL_W = 4 * LAT;
         logic [DL_W-1:0] r_dl;
         always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
               r_dl <= '0;
            end else if (pix_tick) begin
               r_dl <= (r_dl << 4) | DL_W'(w_st0);
            end
         end
         assign w_std = r_dl[DL_W-1 -: 4];
      end
   endgenerate

   always_comb begin
      w_red   = '0;
      w_green = '0;
      w_blue  = '0;
      if (w_std[2]) begin
         if (w_std[3] && (icon_pixel == 2'b01)) begin
            w_red = '1;
         end else if (w_std[3] && (icon_pixel == 2'b10)) begin
            w_red   = '1;
            w_green = '1;
            w_blue  = '1;
         end else if (w_std[3] && (icon_pixel == 2'b11)) begin
            w_red = '0;
         end else begin
            w_red   = f_expand3(world_pixel[7:5]);
            w_green = f_expand3(world_pixel[4:2]);
            w_blue  = f_expand2(world_pixel[1:0]);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         horiz_sync <= ~L_POL;
         vert_sync  <= ~L_POL;
         video_on   <= 1'b0;
         red        <= '0;
         green      <= '0;
         blue       <= '0;
      end else if (pix_tick) begin
         horiz_sync <= w_std[0] ? L_POL : ~L_POL;
         vert_sync  <= w_std[1] ? L_POL : ~L_POL;
         video_on   <= w_std[2];
         red        <= w_red;
         green      <= w_green;
         blue       <= w_blue;
      end
   end

endmodule
